// File: rtl/led_flow_pkg.sv
// Shared definitions for the flowing-LED sequencer: mode and direction encodings
// plus the default prescaler period used when LED_FLOW_INTERNAL_TICK_EN is defined.
package led_flow_pkg;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'd0,
        MODE_SHR   = 2'd1,
        MODE_PP    = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int DEFAULT_TICK_DIV = 25_000_000;
    localparam int LED_NUM_MIN      = 2;
    localparam int LED_NUM_MAX      = 16;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clk cycles;
// only instantiated when LED_FLOW_INTERNAL_TICK_EN is defined.
module led_tick_gen
    import led_flow_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_ONE;
        end
    end

    // Decoded from the registered count so the first tick lands TICK_DIV edges after reset.
    assign tick = (count == CNT_LAST);

endmodule

// File: rtl/led_flow_seq.sv
// Flowing-LED sequencer: shift-left, shift-right, ping-pong and blink patterns
// advanced once per step. Define LED_FLOW_INTERNAL_TICK_EN to use the built-in prescaler.
module led_flow_seq
    import led_flow_pkg::*;
#(
    parameter int LED_NUM  = 4,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [1:0]         mode,
    input  logic               pause,
    output logic [LED_NUM-1:0] led,
    output logic               wrap
);

    localparam logic [LED_NUM-1:0] LED_LSB = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] LED_MSB = {1'b1, {(LED_NUM-1){1'b0}}};
    localparam logic [LED_NUM-1:0] LED_ALL = {LED_NUM{1'b1}};

    mode_e mode_q;
    mode_e mode_in;
    dir_e  dir;
    logic  tick_eff;
    logic  step;
    logic  led_onehot;

`ifdef LED_FLOW_INTERNAL_TICK_EN
    logic unused_tick;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick_eff)
    );

    assign unused_tick = tick;
`else
    logic unused_tick_div;

    assign tick_eff        = tick;
    assign unused_tick_div = (TICK_DIV != 0);
`endif

    assign mode_in    = mode_e'(mode);
    assign step       = tick_eff && !pause;
    assign led_onehot = (led != '0) && ((led & (led - LED_LSB)) == '0);

    function automatic logic [LED_NUM-1:0] entry_pattern(input mode_e m);
        case (m)
            MODE_SHR:   return LED_MSB;
            MODE_BLINK: return LED_ALL;
            default:    return LED_LSB;
        endcase
    endfunction

    // Mode changes only take effect on a step; a corrupted pattern in the one-hot modes reloads the entry pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            led    <= LED_LSB;
            mode_q <= MODE_SHL;
            dir    <= DIR_UP;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (step) begin
                if (mode_in != mode_q) begin
                    led    <= entry_pattern(mode_in);
                    mode_q <= mode_in;
                    if (mode_in == MODE_PP) begin
                        dir <= DIR_UP;
                    end
                end else if ((mode_q != MODE_BLINK) && !led_onehot) begin
                    led <= entry_pattern(mode_q);
                    if (mode_q == MODE_PP) begin
                        dir <= DIR_UP;
                    end
                end else begin
                    case (mode_q)
                        MODE_SHL: begin
                            led  <= {led[LED_NUM-2:0], led[LED_NUM-1]};
                            wrap <= led[LED_NUM-1];
                        end
                        MODE_SHR: begin
                            led  <= {led[0], led[LED_NUM-1:1]};
                            wrap <= led[0];
                        end
                        MODE_PP: begin
                            case (dir)
                                DIR_UP: begin
                                    // Already at the top end: bounce instead of shifting the bit out.
                                    if (led[LED_NUM-1]) begin
                                        led <= led >> 1;
                                        dir <= DIR_DOWN;
                                    end else begin
                                        led <= led << 1;
                                        if (led[LED_NUM-2]) begin
                                            dir <= DIR_DOWN;
                                        end
                                    end
                                end
                                DIR_DOWN: begin
                                    if (led[0]) begin
                                        led <= led << 1;
                                        dir <= DIR_UP;
                                    end else begin
                                        led <= led >> 1;
                                        if (led[1]) begin
                                            dir  <= DIR_UP;
                                            wrap <= 1'b1;
                                        end
                                    end
                                end
                            endcase
                        end
                        MODE_BLINK: begin
                            led  <= ~led;
                            wrap <= (led == '0);
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_flow_seq.sv
// Directed self-checking bench for led_flow_seq with LED_NUM=4; the internal
// prescaler path is exercised when LED_FLOW_INTERNAL_TICK_EN is defined.
module tb_led_flow_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [1:0]   mode;
    logic         pause;
    logic [N-1:0] led;
    logic         wrap;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    led_flow_seq #(
        .LED_NUM (N),
        .TICK_DIV(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .mode (mode),
        .pause(pause),
        .led  (led),
        .wrap (wrap)
    );

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [N-1:0] exp_led, input logic exp_wrap);
        compared++;
        assert ({led, wrap} === {exp_led, exp_wrap}) else begin
            mismatched++;
            $error("[TB] FAIL %s: got led=%b wrap=%b, expected led=%b wrap=%b",
                   tag, led, wrap, exp_led, exp_wrap);
        end
    endtask

    task automatic apply_stimulus(input logic t);
        tick = t;
        cycle(1);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        cycle(2);
        rst  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

`ifndef LED_FLOW_INTERNAL_TICK_EN
    initial begin
        logic [N-1:0] pp_exp [8];
        pp_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};

        rst   = 1'b1;
        tick  = 1'b0;
        mode  = 2'd0;
        pause = 1'b0;
        do_reset();
        check_output("reset", 4'b0001, 1'b0);
        cycle(2);
        check_output("hold_no_tick", 4'b0001, 1'b0);

        // Shift left, one tick every third cycle
        apply_stimulus(1'b1); check_output("shl_1", 4'b0010, 1'b0); cycle(2);
        apply_stimulus(1'b1); check_output("shl_2", 4'b0100, 1'b0); cycle(2);
        apply_stimulus(1'b1); check_output("shl_3", 4'b1000, 1'b0); cycle(2);
        apply_stimulus(1'b1); check_output("shl_wrap", 4'b0001, 1'b1);
        cycle(1);
        check_output("shl_wrap_one_cycle", 4'b0001, 1'b0);

        // Ping-pong: first tick loads the entry pattern, then back-to-back ticks
        do_reset();
        mode = 2'd2;
        apply_stimulus(1'b1);
        check_output("pp_entry", 4'b0001, 1'b0);
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1);
            check_output($sformatf("pp_step_%0d", i), pp_exp[i], (i == 5));
        end
        tick = 1'b0;
        cycle(1);
        check_output("pp_idle", 4'b0100, 1'b0);

        // Switch shift-left to blink
        do_reset();
        mode = 2'd0;
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        check_output("pre_blink", 4'b0100, 1'b0);
        mode = 2'd3;
        cycle(1);
        check_output("mode_change_no_tick", 4'b0100, 1'b0);
        apply_stimulus(1'b1); check_output("blink_entry", 4'b1111, 1'b0);
        apply_stimulus(1'b1); check_output("blink_off", 4'b0000, 1'b0);
        apply_stimulus(1'b1); check_output("blink_on_wrap", 4'b1111, 1'b1);
        cycle(1);
        check_output("blink_wrap_one_cycle", 4'b1111, 1'b0);

        // Pause with a deferred mode change
        do_reset();
        mode = 2'd0;
        apply_stimulus(1'b1);
        check_output("pre_pause", 4'b0010, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) mode = 2'd1;
            apply_stimulus(1'b1);
            check_output($sformatf("paused_%0d", i), 4'b0010, 1'b0);
        end
        pause = 1'b0;
        apply_stimulus(1'b1); check_output("shr_entry", 4'b1000, 1'b0);
        apply_stimulus(1'b1); check_output("shr_1", 4'b0100, 1'b0);
        apply_stimulus(1'b1); check_output("shr_2", 4'b0010, 1'b0);
        apply_stimulus(1'b1); check_output("shr_3", 4'b0001, 1'b0);
        apply_stimulus(1'b1); check_output("shr_wrap", 4'b1000, 1'b1);
        apply_stimulus(1'b1); check_output("shr_4", 4'b0100, 1'b0);
        apply_stimulus(1'b1); check_output("shr_5", 4'b0010, 1'b0);

        // Reset together with tick wins; mode_q returns to shift-left
        rst  = 1'b1;
        tick = 1'b1;
        cycle(1);
        rst  = 1'b0;
        tick = 1'b0;
        check_output("rst_with_tick", 4'b0001, 1'b0);
        apply_stimulus(1'b1);
        check_output("post_rst_shr_entry", 4'b1000, 1'b0);
        mode = 2'd0;
        apply_stimulus(1'b1); check_output("back_to_shl_entry", 4'b0001, 1'b0);
        apply_stimulus(1'b1); check_output("back_to_shl_step", 4'b0010, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
`else
    initial begin
        logic [N-1:0] exp_led;

        mode  = 2'd0;
        pause = 1'b0;
        tick  = 1'b1;
        rst   = 1'b1;
        cycle(1);
        rst   = 1'b0;
        check_output("int_reset", 4'b0001, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            cycle(1);
            exp_led = (e < 4) ? 4'b0001 : (e < 8) ? 4'b0010 : (e < 12) ? 4'b0100 : 4'b1000;
            check_output($sformatf("int_edge_%0d", e), exp_led, 1'b0);
        end
        pause = 1'b1;
        cycle(4);
        check_output("int_paused", 4'b1000, 1'b0);
        pause = 1'b0;
        cycle(4);
        check_output("int_prescaler_kept_running", 4'b0001, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
`endif

endmodule
